// File: rtl/serializer_pkg.sv
// Shared types and sizing helpers for the serializer family.
package serializer_pkg;

  typedef enum logic {S_IDLE, S_SHIFT} ser_state_t;

  // Remaining-bit counter must hold WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

  localparam int DEFAULT_WIDTH = 8;
  localparam int CNT_W         = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/bit_down_counter.sv
// Loadable down-counter that saturates at zero and flags when it is there.
module bit_down_counter #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  assign zero = (count == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (dec && !zero) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out front end: valid/ready word in, one registered bit per clock on x.
module piso_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1,
  parameter bit IDLE_BIT  = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             x,
  output logic             x_valid,
  output logic             last,
  output logic             busy
);

  localparam int                CNT_BITS = cnt_width(WIDTH);
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(WIDTH - 1);

  ser_state_t          state, state_next;
  logic [WIDTH-1:0]    sreg, sreg_next;
  logic [CNT_BITS-1:0] count;
  logic                cnt_zero, cnt_load, cnt_dec;
  logic                x_next, x_valid_next, last_next, accept;

  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? (v << 1) : (v >> 1);
  endfunction

  bit_down_counter #(.W(CNT_BITS)) u_count (
    .clock (clock),
    .reset (reset),
    .load  (cnt_load),
    .value (CNT_LOAD),
    .dec   (cnt_dec),
    .count (count),
    .zero  (cnt_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // The first bit goes straight from data_in to x on the accept edge, so the
  // shift register keeps the word already advanced by one position.
  always_comb begin
    state_next   = state;
    sreg_next    = sreg;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    x_next       = IDLE_BIT;
    x_valid_next = 1'b0;
    last_next    = 1'b0;
    data_ready   = !reset && ((state == S_IDLE) || cnt_zero);
    accept       = data_valid && data_ready;
    if (accept) begin
      state_next   = S_SHIFT;
      sreg_next    = shift_once(data_in);
      cnt_load     = 1'b1;
      x_next       = head_bit(data_in);
      x_valid_next = 1'b1;
    end else if (state == S_SHIFT && !cnt_zero) begin
      sreg_next    = shift_once(sreg);
      cnt_dec      = 1'b1;
      x_next       = head_bit(sreg);
      x_valid_next = 1'b1;
      last_next    = (count == CNT_BITS'(1));
    end else begin
      state_next   = S_IDLE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sreg    <= '0;
      x       <= IDLE_BIT;
      x_valid <= 1'b0;
      last    <= 1'b0;
    end else begin
      sreg    <= sreg_next;
      x       <= x_next;
      x_valid <= x_valid_next;
      last    <= last_next;
    end
  end

  assign busy = (state == S_SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: an MSB-first/idle-0 and an LSB-first/idle-1 serializer share one stimulus stream.
module tb_piso_serializer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       rdy_a, x_a, xv_a, last_a, busy_a;
  logic       rdy_b, x_b, xv_b, last_b, busy_b;

  int checks = 0;
  int errors = 0;
  int model_cnt = 0;     // bits of the current word still to appear, including the one on x
  bit mon_en = 1'b0;
  logic [1:0] q_a[$];    // {last, x} expected in order
  logic [1:0] q_b[$];

  always #5 clock = ~clock;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(0)) dut_a (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy_a), .x(x_a), .x_valid(xv_a), .last(last_a), .busy(busy_a));

  piso_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(1)) dut_b (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy_b), .x(x_b), .x_valid(xv_b), .last(last_b), .busy(busy_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word expands into its 8 bits in shift order.
  task automatic push_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      q_a.push_back({(i == 7), w[7 - i]});
      q_b.push_back({(i == 7), w[i]});
    end
  endtask

  // One clock of stimulus; entered and left 1 time unit after a rising edge.
  task automatic cycle(input logic v, input logic [7:0] d, output bit acc);
    bit exp_ready;
    data_valid = v;
    data_in    = d;
    exp_ready  = (model_cnt <= 1);
    chk("data_ready_a", 32'(rdy_a), 32'(exp_ready));
    chk("data_ready_b", 32'(rdy_b), 32'(exp_ready));
    chk("busy_a", 32'(busy_a), 32'(model_cnt > 0));
    chk("busy_b", 32'(busy_b), 32'(model_cnt > 0));
    @(posedge clock);
    acc = v && exp_ready;
    if (acc) begin
      push_word(d);
      model_cnt = 8;
    end else if (model_cnt > 0) begin
      model_cnt--;
    end
    #1;
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 12 && model_cnt > 0; i++) cycle(1'b0, 8'h00, acc);
    cycle(1'b0, 8'h00, acc);
  endtask

  task automatic send_words(input logic [7:0] w0, input logic [7:0] w1);
    logic [7:0] w[2];
    int idx;
    bit acc;
    w[0] = w0;
    w[1] = w1;
    idx = 0;
    for (int i = 0; i < 40 && idx < 2; i++) begin
      cycle(1'b1, w[idx], acc);
      if (acc) idx++;
    end
    chk("stream_accepts", 32'(idx), 32'd2);
  endtask

  task automatic reset_state_check(input string tag);
    chk({tag, "_x_a"}, 32'(x_a), 32'd0);
    chk({tag, "_x_b"}, 32'(x_b), 32'd1);
    chk({tag, "_xv"}, 32'({xv_a, xv_b}), 32'd0);
    chk({tag, "_last"}, 32'({last_a, last_b}), 32'd0);
    chk({tag, "_busy"}, 32'({busy_a, busy_b}), 32'd0);
    chk({tag, "_ready"}, 32'({rdy_a, rdy_b}), 32'd0);
  endtask

  // Monitors: every cycle either pops an expected bit or expects the idle level.
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        if (xv_a) begin
          if (q_a.size() == 0) begin
            chk("a_unexpected_bit", 32'(xv_a), 32'd0);
          end else begin
            e = q_a.pop_front();
            chk("a_x", 32'(x_a), 32'(e[0]));
            chk("a_last", 32'(last_a), 32'(e[1]));
          end
        end else begin
          chk("a_idle_x", 32'(x_a), 32'd0);
          chk("a_idle_last", 32'(last_a), 32'd0);
        end
      end
    end
  end

  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        if (xv_b) begin
          if (q_b.size() == 0) begin
            chk("b_unexpected_bit", 32'(xv_b), 32'd0);
          end else begin
            e = q_b.pop_front();
            chk("b_x", 32'(x_b), 32'(e[0]));
            chk("b_last", 32'(last_b), 32'(e[1]));
          end
        end else begin
          chk("b_idle_x", 32'(x_b), 32'd1);
          chk("b_idle_last", 32'(last_b), 32'd0);
        end
      end
    end
  end

  initial begin
    bit acc;
    #7;
    reset_state_check("reset_init");
    #3 reset = 1'b0;
    @(posedge clock);
    #1;
    mon_en = 1'b1;

    // Single word 0xCB.
    cycle(1'b1, 8'hCB, acc);
    chk("accept_cb", 32'(acc), 32'd1);
    drain();

    // Back-to-back words with valid held high.
    send_words(8'hB4, 8'h5A);
    drain();

    // data_in churns while busy; only the last-bit-cycle value is taken.
    cycle(1'b1, 8'hFF, acc);
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) cycle(1'b1, 8'($urandom), acc);
    chk("churn_accept", 32'(acc), 32'd1);
    drain();

    // Asynchronous reset in the middle of a word.
    cycle(1'b1, 8'hB4, acc);
    cycle(1'b0, 8'h00, acc);
    cycle(1'b0, 8'h00, acc);
    #2 reset = 1'b1;
    #1;
    reset_state_check("reset_mid");
    q_a.delete();
    q_b.delete();
    model_cnt = 0;
    @(posedge clock);
    #3 reset = 1'b0;
    @(posedge clock);
    #1;
    cycle(1'b1, 8'h81, acc);
    chk("accept_81", 32'(acc), 32'd1);
    drain();

    // Randomized traffic with gaps.
    for (int i = 0; i < 60; i++) cycle(($urandom_range(0, 3) != 0), 8'($urandom), acc);
    drain();
    cycle(1'b0, 8'h00, acc);

    chk("queue_a_empty", 32'(q_a.size()), 32'd0);
    chk("queue_b_empty", 32'(q_b.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
